// File: rtl/timer_multi_core.sv
// Multi-channel timer: one shared prescaler feeding N_CH independent counters, each with
// its own compare, periodic/one-shot mode, sample register and sticky interrupt.
module timer_multi_core #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned N_CH    = 4,
   parameter int unsigned PRESC_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PRESC_W-1:0]       TIMER_PRESCALE,
   input  logic [N_CH-1:0]          TIMER_ENABLE,
   input  logic [N_CH-1:0]          TIMER_MODE,
   input  logic [N_CH-1:0]          TIMER_CLEAR,
   input  logic [N_CH-1:0]          TIMER_SAMPLE,
   input  logic [N_CH*DATA_W-1:0]   TIMER_CMP,
   input  logic [N_CH-1:0]          TIMER_IRQ_CLR,
   output logic [N_CH*DATA_W-1:0]   TIMER_VALUE,
   output logic [N_CH-1:0]          TIMER_IRQ,
   output logic [N_CH-1:0]          TIMER_DONE
);

   logic [PRESC_W-1:0]              r_presc;
   logic [PRESC_W-1:0]              w_presc_d;
   logic                            w_any_en;
   logic                            w_tick;

   logic [N_CH-1:0][DATA_W-1:0]     r_cnt;
   logic [N_CH-1:0][DATA_W-1:0]     w_cnt_d;
   logic [N_CH-1:0][DATA_W-1:0]     r_val;
   logic [N_CH-1:0][DATA_W-1:0]     w_val_d;
   logic [N_CH-1:0]                 r_done;
   logic [N_CH-1:0]                 w_done_d;
   logic [N_CH-1:0]                 r_irq;
   logic [N_CH-1:0]                 w_irq_d;
   logic [N_CH-1:0]                 w_run;
   logic [N_CH-1:0]                 w_match;

   // >= rather than == so a lowered PRESCALE ticks on the next cycle instead of wrapping
   always_comb begin
      w_any_en  = |TIMER_ENABLE;
      w_tick    = w_any_en && (r_presc >= TIMER_PRESCALE);
      w_presc_d = r_presc;
      if (!w_any_en) begin
         w_presc_d = '0;
      end else if (w_tick) begin
         w_presc_d = '0;
      end else begin
         w_presc_d = r_presc + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else begin
         r_presc <= w_presc_d;
      end
   end

   // Channel state: r_done marks EXPIRED; IDLE/RUN follow the enable level directly
   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_run[i]    = TIMER_ENABLE[i] && !r_done[i] && w_tick;
         w_match[i]  = w_run[i] && (r_cnt[i] == TIMER_CMP[i*DATA_W +: DATA_W]);
         w_cnt_d[i]  = r_cnt[i];
         w_done_d[i] = r_done[i];
         if (TIMER_CLEAR[i]) begin
            w_cnt_d[i]  = '0;
            w_done_d[i] = 1'b0;
         end else if (w_match[i]) begin
            if (TIMER_MODE[i]) begin
               w_done_d[i] = 1'b1;
            end else begin
               w_cnt_d[i] = '0;
            end
         end else if (w_run[i]) begin
            w_cnt_d[i] = r_cnt[i] + DATA_W'(1);
         end
         // Match wins over a same-cycle acknowledge
         w_irq_d[i] = w_match[i] || (r_irq[i] && !TIMER_IRQ_CLR[i]);
         w_val_d[i] = TIMER_SAMPLE[i] ? r_cnt[i] : r_val[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_done <= '0;
         r_irq  <= '0;
         r_val  <= '0;
      end else begin
         r_cnt  <= w_cnt_d;
         r_done <= w_done_d;
         r_irq  <= w_irq_d;
         r_val  <= w_val_d;
      end
   end

   always_comb begin
      TIMER_VALUE = r_val;
      TIMER_IRQ   = r_irq;
      TIMER_DONE  = r_done;
   end

endmodule

// File: doc/timer_multi_core.md
# timer_multi_core

Multi-channel successor to the single 64-bit timer core: N_CH independent channels share one programmable prescaler and each channel has its own counter, compare register, periodic/one-shot mode, sample register and interrupt flag. It sits behind the TIMER software-register bank, which drives all inputs as register fields and reads back all outputs. It adds tick division, compare match, auto-reload and interrupt generation, none of which the plain free-running counter provides.

## Interface
- DATA_W, 32: width of each channel counter, compare value and sampled value
- N_CH, 4: number of channels, 1..16
- PRESC_W, 16: prescaler field width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- TIMER_PRESCALE  in  PRESC_W  tick period minus 1, in clk cycles
- TIMER_ENABLE  in  N_CH  per-channel count enable (level)
- TIMER_MODE  in  N_CH  per-channel mode: 0 = periodic, 1 = one-shot
- TIMER_CLEAR  in  N_CH  per-channel synchronous counter/done clear (pulse)
- TIMER_SAMPLE  in  N_CH  per-channel capture strobe (pulse)
- TIMER_CMP  in  N_CH*DATA_W  per-channel compare value; channel i occupies bits [i*DATA_W +: DATA_W]
- TIMER_IRQ_CLR  in  N_CH  per-channel interrupt acknowledge (pulse)
- TIMER_VALUE  out  N_CH*DATA_W  per-channel sampled counter, same packing as TIMER_CMP
- TIMER_IRQ  out  N_CH  per-channel interrupt pending (level, sticky)
- TIMER_DONE  out  N_CH  per-channel one-shot expired flag

## Operation
- Prescaler: presc_cnt (PRESC_W bits) runs while any TIMER_ENABLE bit is high. It forces to 0 when all enable bits are low.
  - tick = (presc_cnt >= TIMER_PRESCALE). On tick presc_cnt <= 0, otherwise presc_cnt + 1.
  - Using >= means a PRESCALE decrease mid-run never wraps: the next cycle ticks.
  - PRESCALE = 0 gives a tick every cycle.
- Channel state per bit i: cnt[i] (DATA_W), done[i], irq[i], val[i]. Each channel is an independent three-state machine:
  - IDLE: enable = 0. Counter holds.
  - RUN: enable = 1 and done = 0. Counts on tick.
  - EXPIRED: done = 1. Counter holds at CMP.
- Counter update, priority high to low:
  1. CLEAR: cnt <= 0, done <= 0. Overrides a same-cycle tick.
  2. enable & ~done & tick & (cnt == CMP): irq <= 1. Then periodic: cnt <= 0. One-shot: done <= 1 and cnt holds.
  3. enable & ~done & tick: cnt <= cnt + 1, modulo 2^DATA_W.
  4. Otherwise hold.
- Period is (CMP+1) ticks. CMP = 0 in periodic mode gives a match on every tick with cnt stuck at 0.
- CMP lowered below the current cnt: the counter runs to 2^DATA_W-1, wraps to 0, then matches. There is no early match.
- IRQ is set-dominant: a match in the same cycle as TIMER_IRQ_CLR leaves irq = 1. CLEAR does not affect irq.
- SAMPLE: val <= cnt as it was before that edge's update. SAMPLE and CLEAR in the same cycle capture the pre-clear value.
- Leaving EXPIRED requires CLEAR. Toggling enable does not clear done.
- Changing MODE while in RUN takes effect at the next match.

## Timing
- Reset: presc_cnt, every cnt, done, irq and val go to 0. TIMER_VALUE = 0, TIMER_IRQ = 0, TIMER_DONE = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- PRESCALE = 0, enable rises before edge k: cnt = 1 after edge k.
- Match at edge k means TIMER_IRQ and TIMER_DONE are visible after edge k.
- SAMPLE at edge k means TIMER_VALUE is updated after edge k.
- rst asserted mid-count: all state clears immediately, without waiting for clk. Counting resumes on the first edge after rst deasserts with enable high.

## Test plan
- Reset/idle: assert rst mid-count with cnt = 0x1234 -> all outputs 0 immediately. Deassert with enable = 0 for 20 cycles -> cnt stays 0.
- Periodic with prescaler: ch0 PRESCALE = 3, CMP = 4, periodic, enable -> irq rises every 20 clk cycles. IRQ_CLR each time -> irq drops next cycle. Sampling just before each match reads 4, just after reads 0.
- One-shot: ch1 PRESCALE = 0, CMP = 9, one-shot -> after 10 cycles done = 1, irq = 1, cnt holds at 9 for 50 cycles. CLEAR -> cnt = 0, done = 0, counting restarts with irq still 1.
- Simultaneous events: IRQ_CLR on the match cycle -> irq stays 1. CLEAR on a tick cycle -> cnt = 0, not 1. SAMPLE with CLEAR -> TIMER_VALUE shows the pre-clear count.
- Wrap and CMP change: DATA_W = 8, CMP changed from 200 to 10 at cnt = 50 -> no irq until cnt wraps 255 -> 0 and reaches 10, which is 216 ticks after the change.
- Channel independence: N_CH = 4, channels with CMP 1/2/3/4, mixed modes, random enable/clear -> each channel matches a per-channel reference model. Disabling all channels resets the prescaler, so the first tick after re-enable arrives PRESCALE+1 cycles later.
